// File: rtl/param_seq_det.sv
// rtl/param_seq_det.sv - parametrised serial bit-pattern detector with saturating match counter
// Full-window compare of the last PAT_LEN accepted bits; Mealy or Moore output selectable.
module param_seq_det #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 OVERLAP = 1,
  parameter int                 MOORE   = 0,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               out_q, out_d;
  logic [PAT_LEN-1:0] window;
  logic               hit;

  always_comb begin
    window = {hist_q, in};
    // en gates first so an X on in while idle cannot reach hit or state
    hit    = en && (fill_q == FILL_MAX) && (window == PATTERN);
    hist_d = hist_q;
    fill_d = fill_q;
    if (en) begin
      hist_d = window[PAT_LEN-2:0];
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      if (hit && (OVERLAP == 0)) fill_d = '0;
    end

    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    sat_d = (cnt_d == CNT_MAX);
    out_d = hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      out_q  <= out_d;
    end
  end

  assign out       = (MOORE != 0) ? out_q : hit;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule
